visualizador_7seg: RTL and testbench
====================================

Name: visualizador_7seg

Overview:
- Downstream consumer of the 10 kHz divided clock (`clk_dividido`) on the Booth signed-multiplier board.
- Accepts a signed product from the Booth datapath and converts it to sign plus BCD with a sequential double-dabble engine.
- Time-multiplexes the result onto an 8-digit common-anode 7-segment display, advancing one digit per `clk_dividido` rising edge.
- All logic runs in the single `clk` domain; `clk_dividido` is treated as data (synchronised and edge-detected), never used as a clock.

Parameters:
- WIDTH, 16, width of signed product input (two's complement).
- BCD_DIG, 5, number of BCD digits produced; must cover 2^(WIDTH-1).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous reset, active-low.
- clk_dividido  input  1  10 kHz square wave from the clock divider; scan timebase.
- producto  input  WIDTH  signed product to display.
- valido  input  1  one-cycle strobe: capture producto.
- ocupado  output  1  high while a conversion is in progress.
- an  output  8  digit anodes, active-low, one-hot; an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; constant 1 (off).

Behaviour:
- Reset (reset=0, async), all registers cleared:
  - an=8'hFE, seg=7'h40 ('0'), dp=1, ocupado=0, FSM=IDLE.
  - Displayed value = +0, digit index = 0, synchroniser FFs = 0.
- Scan timebase:
  - clk_dividido passes through a 2-FF synchroniser plus an edge FF; tick = sync & ~prev.
  - On tick, the digit index increments and wraps 7→0. an and seg update on the clk edge after the tick.
  - Net latency: 3 clk cycles after the clk_dividido rising edge; exactly one advance per rising edge, none on falling edges.
- Conversion FSM, states IDLE, LOAD, SHIFT, DONE:
  - IDLE: ocupado=0. When valido=1, capture producto and go to LOAD.
  - LOAD: sign = MSB; magnitude = sign ? -producto : producto, held as WIDTH-bit unsigned (-2^(WIDTH-1) → 2^(WIDTH-1), no overflow). Clear the BCD accumulator, load the shift counter with WIDTH, go to SHIFT.
  - SHIFT: each cycle, every BCD nibble ≥5 gets +3, then {bcd, mag} shifts left by 1. After WIDTH cycles go to DONE.
  - DONE: copy sign and BCD into the display registers in one cycle, then go to IDLE.
  - ocupado=1 in LOAD, SHIFT and DONE: WIDTH+2 cycles total (18 at default).
  - The display registers change only in DONE, so the old value stays visible during a conversion.
- valido while ocupado=1 (including the DONE cycle) is ignored, not queued.
- valido on the first cycle ocupado=0 is accepted.
- Digit content, by index i:
  - i < BCD_DIG: BCD digit i.
  - Leading-zero blanking: digit i is blank (7'h7F) if it and all higher BCD digits are 0, except digit 0, which is always shown.
  - If sign=1: '-' (7'h3F) appears in the index immediately left of the most-significant shown digit.
  - All other indices are blank.
  - The sign is never set for zero: -0 cannot occur, because magnitude 0 implies producto=0.
- Segment codes, '0'..'9': 40,79,24,30,19,12,02,78,00,10 (hex).
- Asserting reset mid-conversion aborts immediately. After release the display shows 0 until the next valido.
- A scan tick coincident with DONE: the index advances, and seg shows the new value at the new index.

Test Plan:
- Reset, then release; drive clk_dividido at 10 kHz → an=FE, seg=40 first. After each rising edge (3-cycle latency) an walks FD, FB, …, 7F, then wraps to FE. Digit 0 shows 40; all other digits show 7F.
- producto=16'sd1234, valido 1 cycle → ocupado high exactly 18 cycles. Scan shows digit0=19, d1=30, d2=24, d3=79, d4..d7=7F.
- producto=-16384 → d0=19 ('4'), d1=00 ('8'), d2=30 ('3'), d3=02 ('6'), d4=79 ('1'), d5=3F ('-'), d6..d7=7F. producto=-32768 → 8,6,7,2,3 with '-' at d5.
- producto=-1 → d0=79, d1=3F, rest 7F.
- Display 1234, then valido with 99 → d0=10, d1=10, d2..d7=7F.
- Display 1234, then pulse valido with 555 during cycle 5 of busy, and again with 77 in the DONE cycle → both ignored; 1234 persists. The next valido one cycle after ocupado falls is accepted.
- Pull reset low during SHIFT of 1234 → ocupado=0 and an=FE/seg=40 asynchronously. After release, 0 is displayed and no stale digits appear.

Source files
------------

// File: rtl/visualizador_7seg.sv
// Signed product to sign+BCD display: a sequential double-dabble converter
// feeding an 8-digit multiplexed common-anode 7-segment scanner.
module visualizador_7seg #(
  parameter int WIDTH   = 16,
  parameter int BCD_DIG = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_dividido,
  input  logic [WIDTH-1:0] producto,
  input  logic             valido,
  output logic             ocupado,
  output logic [7:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * BCD_DIG;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_prod;
  logic [WIDTH-1:0] r_mag;
  logic             r_sign;
  logic [BW-1:0]    r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_disp_sign;
  logic [BW-1:0]    r_disp_bcd;
  logic             r_sync1, r_sync2, r_prev;
  logic [2:0]       r_idx;
  logic [7:0]       r_an;
  logic [6:0]       r_seg;

  logic [BW-1:0]    w_bcd_adj;
  logic             w_tick;
  logic [2:0]       w_idx_nxt;
  logic             w_disp_sign_nxt;
  logic [BW-1:0]    w_disp_bcd_nxt;
  logic [3:0]       w_nib [8];
  logic [3:0]       w_msd;
  logic [6:0]       w_seg_nxt;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < BCD_DIG; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_prod      <= '0;
      r_mag       <= '0;
      r_sign      <= 1'b0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_disp_sign <= 1'b0;
      r_disp_bcd  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valido) begin
            r_prod  <= producto;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          // Held unsigned, so the most negative input maps to 2^(WIDTH-1) cleanly
          r_sign  <= r_prod[WIDTH-1];
          r_mag   <= r_prod[WIDTH-1] ? (~r_prod) + WIDTH'(1) : r_prod;
          r_bcd   <= '0;
          r_cnt   <= CW'(WIDTH);
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_bcd <= {w_bcd_adj[BW-2:0], r_mag[WIDTH-1]};
          r_mag <= {r_mag[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= DONE;
        end
        DONE: begin
          r_disp_sign <= r_sign;
          r_disp_bcd  <= r_bcd;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_tick          = r_sync2 & ~r_prev;
  assign w_idx_nxt       = w_tick ? r_idx + 3'd1 : r_idx;
  assign w_disp_sign_nxt = (r_state == DONE) ? r_sign : r_disp_sign;
  assign w_disp_bcd_nxt  = (r_state == DONE) ? r_bcd  : r_disp_bcd;

  always_comb begin
    for (int i = 0; i < 8; i++) w_nib[i] = 4'd0;
    for (int i = 0; i < BCD_DIG; i++) w_nib[i] = w_disp_bcd_nxt[4*i +: 4];
  end

  // Highest non-zero digit; digit 0 is always shown even for zero
  always_comb begin
    w_msd = 4'd0;
    for (int i = 1; i < BCD_DIG; i++) begin
      if (w_nib[i] != 4'd0) w_msd = 4'(i);
    end
  end

  always_comb begin
    w_seg_nxt = 7'h7F;
    if ({1'b0, w_idx_nxt} <= w_msd)
      w_seg_nxt = f_seg(w_nib[w_idx_nxt]);
    else if (w_disp_sign_nxt && ({1'b0, w_idx_nxt} == w_msd + 4'd1))
      w_seg_nxt = 7'h3F;
  end

  // Outputs are built from next-cycle index and display so a DONE coinciding
  // with a scan tick shows the new value at the new digit immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_idx   <= 3'd0;
      r_an    <= 8'hFE;
      r_seg   <= 7'h40;
    end else begin
      r_sync1 <= clk_dividido;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_idx   <= w_idx_nxt;
      r_an    <= ~(8'd1 << w_idx_nxt);
      r_seg   <= w_seg_nxt;
    end
  end

  assign ocupado = r_busy;
  assign an      = r_an;
  assign seg     = r_seg;
  assign dp      = 1'b1;

endmodule

// File: tb/tb_visualizador_7seg.sv
// Scoreboard bench for visualizador_7seg: a decimal reference model predicts the
// 8-digit pattern per accepted product; a monitor checks the live scan every cycle.
module tb_visualizador_7seg;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clk_dividido = 1'b0;
  logic [WIDTH-1:0] producto = '0;
  logic             valido = 1'b0;
  logic             ocupado;
  logic [7:0]       an;
  logic [6:0]       seg;
  logic             dp;

  always #5 clk = ~clk;

  visualizador_7seg #(.WIDTH(WIDTH), .BCD_DIG(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_dividido (clk_dividido),
    .producto     (producto),
    .valido       (valido),
    .ocupado      (ocupado),
    .an           (an),
    .seg          (seg),
    .dp           (dp)
  );

  typedef logic [7:0][6:0] pat_t;

  pat_t sb_q[$];
  pat_t cur_exp;
  int   total = 0;
  int   bad = 0;
  bit   scan_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Decimal digits of |v|, blank above the top digit, '-' just left of it if negative
  function automatic pat_t model(input int v);
    pat_t p;
    int   mag;
    bit   neg;
    int   nd;
    int   d[8];
    neg = (v < 0);
    mag = neg ? -v : v;
    for (int i = 0; i < 8; i++) d[i] = 0;
    nd = 0;
    do begin
      d[nd] = mag % 10;
      mag   = mag / 10;
      nd++;
    end while (mag > 0);
    for (int i = 0; i < 8; i++) begin
      if (i < nd)                p[i] = digit_code(d[i]);
      else if (neg && i == nd)   p[i] = 7'h3F;
      else                       p[i] = 7'h7F;
    end
    return p;
  endfunction

  // Scan timebase, scaled down to 16 clk per period so full sweeps stay short
  initial begin
    forever begin
      repeat (8) @(posedge clk);
      #1 clk_dividido = scan_en ? ~clk_dividido : 1'b0;
    end
  end

  // Monitor: predicts the digit index from observed rising edges (3-cycle latency),
  // pops the expected pattern when ocupado falls, and checks an/seg/dp each cycle.
  initial begin
    int   m_idx;
    int   pend;
    int   busy_cnt;
    bit   prev_div;
    bit   prev_oc;
    logic [7:0] ea;
    m_idx = 0; pend = 0; busy_cnt = 0; prev_div = 1'b0; prev_oc = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_idx = 0; pend = 0; busy_cnt = 0; prev_div = clk_dividido; prev_oc = 1'b0;
        continue;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) m_idx = (m_idx + 1) % 8;
      end
      if (clk_dividido && !prev_div) pend = 3;
      prev_div = clk_dividido;
      if (ocupado) busy_cnt++;
      if (!ocupado && prev_oc) begin
        chk("busy_len", busy_cnt, WIDTH + 2);
        busy_cnt = 0;
        chk("done_has_expect", sb_q.size() > 0 ? 1 : 0, 1);
        if (sb_q.size() > 0) cur_exp = sb_q.pop_front();
      end
      prev_oc = ocupado;
      ea = ~(8'd1 << m_idx);
      chk("an", an, ea);
      chk($sformatf("seg_d%0d", m_idx), seg, cur_exp[m_idx]);
      chk("dp", dp, 1);
    end
  end

  // Caller sits on a negedge; valido is sampled at the following posedge.
  task automatic pulse(input int v, input bit accept);
    logic [WIDTH-1:0] pv;
    pv = WIDTH'(v);
    producto = pv;
    valido = 1'b1;
    if (accept) sb_q.push_back(model(int'($signed(pv))));
    @(negedge clk);
    valido = 1'b0;
  endtask

  task automatic conv(input int v, input int hold);
    pulse(v, 1'b1);
    repeat (hold) @(negedge clk);
  endtask

  initial begin
    int rv;
    cur_exp = model(0);
    #2 reset = 1'b0;
    #1;
    chk("rst_an", an, 8'hFE);
    chk("rst_seg", seg, 7'h40);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_dp", dp, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    scan_en = 1'b1;
    repeat (150) @(negedge clk);

    conv(1234, 150);
    conv(-16384, 150);
    conv(-32768, 150);
    conv(-1, 150);
    conv(32767, 150);
    conv(0, 150);
    conv(1234, 150);
    conv(99, 150);

    // Busy pulses at cycle 5 and in DONE are dropped; first idle cycle is accepted
    conv(1234, 150);
    pulse(1234, 1'b1);
    repeat (4) @(negedge clk);
    pulse(555, 1'b0);
    repeat (12) @(negedge clk);
    pulse(77, 1'b0);
    pulse(4321, 1'b1);
    repeat (150) @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      if (k % 3 == 0) rv = int'($urandom_range(0, 40)) - 20;
      else            rv = int'($signed(WIDTH'($urandom)));
      conv(rv, int'($urandom_range(18, 70)));
    end
    repeat (150) @(negedge clk);

    // Reset in the middle of a conversion
    scan_en = 1'b0;
    repeat (20) @(negedge clk);
    pulse(1234, 1'b1);
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_ocupado", ocupado, 0);
    chk("abort_an", an, 8'hFE);
    chk("abort_seg", seg, 7'h40);
    sb_q.delete();
    cur_exp = model(0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    scan_en = 1'b1;
    repeat (200) @(negedge clk);

    chk("queue_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
